// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared constants and state encodings for the pipeline
// stall/flush sequencer.
//   NSTG           number of pipeline stages
//   STG_IF..STG_WB bit index of each stage in the stall/flush vectors
//   ex_state_e     EX divider handshake FSM states
//   mem_state_e    MEM dmem handshake FSM states
package pipe_ctrl_pkg;

   localparam int NSTG   = 5;
   localparam int STG_IF = 0;
   localparam int STG_ID = 1;
   localparam int STG_EX = 2;
   localparam int STG_MEM = 3;
   localparam int STG_WB = 4;

   typedef enum logic [1:0] {
      E_IDLE = 2'd0,
      E_BUSY = 2'd1,
      E_DONE = 2'd2
   } ex_state_e;

   typedef enum logic {
      M_IDLE = 1'b0,
      M_WAIT = 1'b1
   } mem_state_e;

endpackage

// File: rtl/pipe_mem_waiter.sv
// pipe_mem_waiter: MEM-stage dmem request/ack handshake plus wait timeout.
//   clk, rstn     clock, async active-low reset
//   mem_req_i     MEM holds a valid load/store
//   mem_ack_i     dmem acknowledge
//   mem_req_o     dmem request (0 while in reset)
//   mem_stall_o   request outstanding and not acknowledged this cycle
//   err_o         sticky timeout flag, cleared only by reset
module pipe_mem_waiter
   import pipe_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255
) (
   input  logic clk,
   input  logic rstn,
   input  logic mem_req_i,
   input  logic mem_ack_i,
   output logic mem_req_o,
   output logic mem_stall_o,
   output logic err_o
);

   localparam int CW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CW-1:0] CMAX = CW'(MEM_TIMEOUT);

   mem_state_e      r_state, w_state_nxt;
   logic [CW-1:0]   r_cnt, w_cnt_nxt;
   logic            r_err;
   logic            w_req;
   logic            w_wait_tick;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= M_IDLE;
         r_cnt   <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_wait_tick && (w_cnt_nxt == CMAX))
            r_err <= 1'b1;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_req       = 1'b0;
      case (r_state)
         M_IDLE: begin
            w_req = mem_req_i;
            // same-cycle ack is a zero-wait access: no M_WAIT visit
            if (mem_req_i && !mem_ack_i)
               w_state_nxt = M_WAIT;
         end
         M_WAIT: begin
            w_req = 1'b1;
            if (mem_ack_i)
               w_state_nxt = M_IDLE;
         end
         default: w_state_nxt = M_IDLE;
      endcase
   end

   // counter only runs on unacknowledged wait cycles; any other cycle,
   // including the ack that leaves M_WAIT, clears it
   assign w_wait_tick = (r_state == M_WAIT) && !mem_ack_i;

   always_comb begin
      w_cnt_nxt = '0;
      if (w_wait_tick)
         w_cnt_nxt = (r_cnt == CMAX) ? r_cnt : r_cnt + CW'(1);
   end

   // rstn gating keeps the combinational request low during reset
   assign mem_req_o   = w_req & rstn;
   assign mem_stall_o = mem_req_o & ~mem_ack_i;
   assign err_o       = r_err;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush sequencer for the 5-stage pipeline.
//   clk, rstn      clock, async active-low reset
//   ld_hazard_i    load-use hazard request
//   br_redirect_i  EX branch mispredict (held while EX frozen)
//   div_req_i      EX holds a div/mod; div_done_i divider result pulse
//   div_start_o    divider start pulse
//   mem_req_i/mem_ack_i/mem_req_o  dmem handshake
//   stall_o        per-stage pipeline register hold (bit = stage index)
//   flush_o        per-stage bubble insert
//   redirect_o     accepted redirect
//   err_o          sticky MEM timeout flag
// Priority: MEM stall > EX stall > redirect > load-use hazard.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            ld_hazard_i,
   input  logic            br_redirect_i,
   input  logic            div_req_i,
   input  logic            div_done_i,
   output logic            div_start_o,
   input  logic            mem_req_i,
   input  logic            mem_ack_i,
   output logic            mem_req_o,
   output logic [NSTG-1:0] stall_o,
   output logic [NSTG-1:0] flush_o,
   output logic            redirect_o,
   output logic            err_o
);

   ex_state_e       r_ex_state, w_ex_nxt;
   logic            w_div_start;
   logic            w_ex_stall;
   logic            w_mem_stall;
   logic [NSTG-1:0] w_stall, w_flush;
   logic            w_redir;

   pipe_mem_waiter #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_mem (
      .clk         (clk),
      .rstn        (rstn),
      .mem_req_i   (mem_req_i),
      .mem_ack_i   (mem_ack_i),
      .mem_req_o   (mem_req_o),
      .mem_stall_o (w_mem_stall),
      .err_o       (err_o)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_ex_state <= E_IDLE;
      else       r_ex_state <= w_ex_nxt;
   end

   // E_DONE burns one cycle so the still-held div_req_i cannot
   // restart the divider before ID->EX advances
   always_comb begin
      w_ex_nxt    = r_ex_state;
      w_div_start = 1'b0;
      case (r_ex_state)
         E_IDLE: if (div_req_i) begin
            w_div_start = 1'b1;
            w_ex_nxt    = E_BUSY;
         end
         E_BUSY: if (div_done_i) w_ex_nxt = E_DONE;
         E_DONE: w_ex_nxt = E_IDLE;
         default: w_ex_nxt = E_IDLE;
      endcase
   end

   assign div_start_o = w_div_start & rstn;
   assign w_ex_stall  = (w_div_start | (r_ex_state == E_BUSY)) & rstn;

   always_comb begin
      w_stall = '0;
      w_flush = '0;
      w_redir = 1'b0;
      if (w_mem_stall) begin
         w_stall[STG_IF]  = 1'b1;
         w_stall[STG_ID]  = 1'b1;
         w_stall[STG_EX]  = 1'b1;
         w_stall[STG_MEM] = 1'b1;
         w_flush[STG_WB]  = 1'b1;
      end else if (w_ex_stall) begin
         w_stall[STG_IF]  = 1'b1;
         w_stall[STG_ID]  = 1'b1;
         w_stall[STG_EX]  = 1'b1;
         w_flush[STG_MEM] = 1'b1;
      end else if (br_redirect_i) begin
         // wrong-path ID and EX instructions are discarded, which also
         // makes any pending load-use hazard moot
         w_flush[STG_ID] = 1'b1;
         w_flush[STG_EX] = 1'b1;
         w_redir         = 1'b1;
      end else if (ld_hazard_i) begin
         w_stall[STG_IF] = 1'b1;
         w_stall[STG_ID] = 1'b1;
         w_flush[STG_EX] = 1'b1;
      end
   end

   assign stall_o    = rstn ? w_stall : '0;
   assign flush_o    = rstn ? w_flush : '0;
   assign redirect_o = w_redir & rstn;

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline (IF, ID, EX, MEM, WB). It merges the load-use hazard request, the multi-cycle divider handshake in EX, the data-memory request/acknowledge handshake in MEM, and the EX-stage branch redirect. It drives one stall bit and one flush (bubble) bit per pipeline register. It owns the divider-start and dmem-request handshakes.

Parameters:
MEM_TIMEOUT, 255, MEM wait cycles without ack before err_o sets; counter width is $clog2(MEM_TIMEOUT+1)
NSTG, 5, number of pipeline stages (fixed; stage index order IF=0, ID=1, EX=2, MEM=3, WB=4)

Ports:
clk  in  1  system clock, rising edge
rstn  in  1  asynchronous active-low reset
ld_hazard_i  in  1  load-use hazard request from the hazard unit
br_redirect_i  in  1  EX branch mispredict; held while EX is frozen
div_req_i  in  1  EX holds a valid div/mod instruction
div_done_i  in  1  divider result valid (single-cycle pulse)
div_start_o  out  1  divider start pulse
mem_req_i  in  1  MEM holds a valid load/store
mem_ack_i  in  1  dmem acknowledge
mem_req_o  out  1  dmem request
stall_o  out  NSTG  hold the pipeline register feeding stage i
flush_o  out  NSTG  insert a bubble into stage i
redirect_o  out  1  accepted redirect; PC takes the branch target
err_o  out  1  sticky MEM timeout flag

Behaviour:
- Reset (rstn=0, async): both FSMs go to IDLE, the timeout counter goes to 0, err_o=0. All outputs are 0 while in reset. An in-flight divide or memory access is abandoned; the divider and dmem share rstn.
- EX FSM, states E_IDLE/E_BUSY/E_DONE:
  - E_IDLE & div_req_i: div_start_o=1 (combinational, this cycle only), next state E_BUSY.
  - E_BUSY & div_done_i: next state E_DONE. Otherwise remain in E_BUSY.
  - E_DONE: unconditional return to E_IDLE. This state prevents the held div_req_i from restarting the divider.
  - ex_stall = (E_IDLE & div_req_i) | E_BUSY. There is no stall in E_DONE.
- MEM FSM, states M_IDLE/M_WAIT:
  - mem_req_o = (M_IDLE & mem_req_i) | M_WAIT.
  - M_IDLE & mem_req_i & !mem_ack_i: next state M_WAIT. A same-cycle ack is a zero-wait access and the FSM stays in M_IDLE.
  - M_WAIT & mem_ack_i: next state M_IDLE.
  - mem_stall = mem_req_o & !mem_ack_i. The ack cycle releases combinationally.
- Timeout counter: increments each cycle in M_WAIT without ack, saturates at MEM_TIMEOUT, and clears on leaving M_WAIT. On reaching MEM_TIMEOUT, err_o=1 and stays set until reset. Stalling continues after the timeout; nothing is dropped.
- Priority, highest first; only the winning cause drives stall_o/flush_o:
  - mem_stall: stall=01111, flush=10000.
  - ex_stall: stall=00111, flush=01000.
  - br_redirect_i: stall=00000, flush=00110, redirect_o=1. The redirect supersedes the load-use hazard because the ID instruction is discarded.
  - ld_hazard_i: stall=00011, flush=00100.
  - None of the above: all outputs 0.
- Bit strings above are written MSB=WB … LSB=IF.
- redirect_o = br_redirect_i & !mem_stall & !ex_stall. A frozen EX holds the redirect until release.
- div_start_o is issued even while mem_stall is active, since EX contents are frozen and stable.
- stall_o and flush_o are never both set for the same stage.

Decomposition:
- Shared package: stage index constants STG_IF..STG_WB; EX and MEM state encodings; NSTG.
- One sub-module, pipe_mem_waiter: contains the MEM FSM and the timeout counter. It outputs mem_req_o, mem_stall and err_o.
- The EX FSM and the priority mux stay in pipe_ctrl.

Test Plan:
1. ld_hazard_i=1 for one cycle, all else 0 -> stall_o=00011, flush_o=00100 that cycle; zeros the next cycle.
2. div_req_i held from cycle 0, div_done_i at cycle 5 -> div_start_o=1 at cycle 0 only; stall_o=00111 and flush_o=01000 for cycles 0-5; cycle 6 (E_DONE) all zero; no second start.
3. mem_req_i held, mem_ack_i at cycle 3 -> mem_req_o=1 for cycles 0-3; stall_o=01111 and flush_o=10000 for cycles 0-2; cycle 3 zeros. Zero-wait variant (ack at cycle 0): no stall.
4. Div in E_BUSY plus mem_req_i without ack -> MEM encoding wins (01111/10000). Add br_redirect_i=1 -> redirect_o stays 0 until both stalls clear, then redirect_o=1 with flush_o=00110.
5. br_redirect_i=1 with ld_hazard_i=1 -> stall_o=0, flush_o=00110, redirect_o=1.
6. MEM_TIMEOUT=4, no ack -> err_o rises after 4 M_WAIT cycles and stays 1 after a later ack. Then assert rstn=0 mid-E_BUSY -> all outputs 0 immediately (asynchronously); after release, FSMs are in IDLE.
